shift_add_multiplier_16b: RTL and testbench

Multi-cycle unsigned 16x16 -> 32-bit multiplier built around the team's 16-bit carry-lookahead adder (carry_lookahead_adder_16b).
- It is the sequential consumer stage for that adder: it drives the adder's operands each cycle and captures the adder's sum, plus a carry-out derived from Pg/Gg.
- Radix-2 shift-and-add: one partial product per clock.
- Valid/ready handshake on both input and output.

---
 rtl/shift_add_multiplier_16b_pkg.sv | 27 ++
 rtl/carry_lookahead_adder_16b.sv | 74 +++++++
 rtl/shift_add_multiplier_16b.sv | 132 +++++++++++++
 tb/tb_shift_add_multiplier_16b.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_16b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier_16b_pkg
// Description : Shared declarations for the shift-and-add multiplier: FSM
//               state encoding (visible to the bench for state probing),
//               default geometry and the carry-out helper.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_add_multiplier_16b_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 5;

    // 2-bit encoding; code 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry out of a lookahead adder from its group propagate/generate.
    function automatic logic cla_carry_out(input logic pg, input logic gg, input logic cin);
        return gg | (pg & cin);
    endfunction

endpackage
`default_nettype wire

// File: rtl/carry_lookahead_adder_16b.sv
`default_nettype none
// ============================================================================
// Module      : carry_lookahead_adder_16b
// Description : 16-bit two-level carry-lookahead adder (four 4-bit groups
//               plus a group-level lookahead unit).
// Ports       : A, B     in  16  addends
//               C_in     in  1   carry in
//               Sum      out 16  A + B + C_in (low 16 bits)
//               Pg, Gg   out 1   block propagate / generate
//               overflow out 1   two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module carry_lookahead_adder_16b (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C_in,
    output logic [15:0] Sum,
    output logic        Pg,
    output logic        Gg,
    output logic        overflow
);

    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [15:0] w_bit_c;   // carry into each bit
    logic [3:0]  w_grp_p;
    logic [3:0]  w_grp_g;
    logic [4:0]  w_grp_c;   // carry into each group, [4] is carry out

    assign w_p = A ^ B;
    assign w_g = A & B;

    // Group-level lookahead, fully expanded so no carry depends on a
    // neighbouring carry of the same vector.
    assign w_grp_c[0] = C_in;
    assign w_grp_c[1] = w_grp_g[0] | (w_grp_p[0] & C_in);
    assign w_grp_c[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0])
                      | (w_grp_p[1] & w_grp_p[0] & C_in);
    assign w_grp_c[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1])
                      | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                      | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & C_in);

    assign Pg = &w_grp_p;
    assign Gg = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2])
              | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
              | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0]);
    assign w_grp_c[4] = Gg | (Pg & C_in);

    for (genvar gi = 0; gi < 4; gi++) begin : g_group
        localparam int LSB = 4 * gi;
        logic [3:0] p;
        logic [3:0] g;
        logic       ci;

        assign p  = w_p[LSB +: 4];
        assign g  = w_g[LSB +: 4];
        assign ci = w_grp_c[gi];

        assign w_grp_p[gi] = &p;
        assign w_grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                           | (p[3] & p[2] & p[1] & g[0]);

        assign w_bit_c[LSB]     = ci;
        assign w_bit_c[LSB + 1] = g[0] | (p[0] & ci);
        assign w_bit_c[LSB + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        assign w_bit_c[LSB + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                                | (p[2] & p[1] & p[0] & ci);
    end

    assign Sum      = w_p ^ w_bit_c;
    assign overflow = w_grp_c[4] ^ w_bit_c[15];

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier_16b.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier_16b
// Description : Unsigned 16x16->32 radix-2 shift-and-add multiplier, one
//               partial product per clock through a carry-lookahead adder,
//               valid/ready handshake on input and output.
// Ports       : clk        in  1   clock, rising edge
//               rst        in  1   asynchronous active-high reset
//               in_valid   in  1   A/B valid
//               in_ready   out 1   ready for operands (IDLE only)
//               A, B       in  16  multiplicand, multiplier (unsigned)
//               out_valid  out 1   product valid (DONE only)
//               out_ready  in  1   downstream accepts product
//               product    out 32  A*B
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier_16b
    import shift_add_multiplier_16b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,   // only 16 is supported
    parameter int CNT_W = DEF_CNT_W    // must be able to hold WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic C_ADD_CIN = 1'b0;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_m;
    logic [2*WIDTH-1:0]   r_p;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_load;
    logic                 w_step;
    logic                 w_last;
    logic [WIDTH-1:0]     w_add_b;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_pg;
    logic                 w_gg;
    logic                 w_carry;
    logic                 w_add_ovf_unused;

    // Multiplicand masked by the current multiplier bit: when P[0]=0 the
    // adder passes P[31:16] through with zero carry, which is exactly the
    // plain right shift, so one datapath covers both cases.
    assign w_add_b = r_p[0] ? r_m : '0;

    carry_lookahead_adder_16b u_cla (
        .A        (r_p[2*WIDTH-1:WIDTH]),
        .B        (w_add_b),
        .C_in     (C_ADD_CIN),
        .Sum      (w_sum),
        .Pg       (w_pg),
        .Gg       (w_gg),
        .overflow (w_add_ovf_unused)
    );

    assign w_carry = cla_carry_out(w_pg, w_gg, C_ADD_CIN);
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: multiplicand, product/multiplier shift register, counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_m   <= A;
            r_p   <= {{WIDTH{1'b0}}, B};
            r_cnt <= '0;
        end else if (w_step) begin
            r_p   <= {w_carry, w_sum, r_p[WIDTH-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Product is held in P until the next operand is accepted.
    assign product = r_p;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier_16b.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_multiplier_16b
// Description : Self-checking bench: table of directed products plus
//               hand-written backpressure, busy-ignore and async-reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier_16b;
    import shift_add_multiplier_16b_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int total = 0;
    int bad   = 0;

    shift_add_multiplier_16b #(.WIDTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (op_a),
        .B         (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present operands with in_valid and return just after the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        int guard;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid; bounded.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (in_ready) busy_ok = 1'b0;
            if (out_valid) break;
        end
    endtask

    initial begin
        int          lat;
        logic        busy_ok;
        logic        stable;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000};
        vecs[4] = '{16'h1234, 16'h0001, 32'h00001234};
        vecs[5] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
        vecs[6] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[7] = '{16'hFFFF, 16'h0002, 32'h0001FFFE};
        vecs[8] = '{16'h0002, 16'hFFFF, 32'h0001FFFE};
        vecs[9] = '{16'h00FF, 16'h00FF, 32'h0000FE01};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = 16'h0;
        op_b      = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product",   product,        32'h0);
        check("rst_state",     32'(dut.r_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of directed products, out_ready held high
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat, busy_ok);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
            check($sformatf("vec%0d_busy", i), 32'(busy_ok), 32'd1);
            check($sformatf("vec%0d_product", i), product, vecs[i].exp);
            @(posedge clk); #1;
            check($sformatf("vec%0d_back_idle", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: result held, new operands refused while in DONE
        out_ready = 1'b0;
        start_op(16'h0007, 16'h0009);
        wait_done(lat, busy_ok);
        check("bp_latency", 32'(lat), 32'd16);
        op_a     = 16'h0001;
        op_b     = 16'h0001;
        in_valid = 1'b1;
        stable   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!out_valid || product !== 32'h0000003F || in_ready) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_product", product, 32'h0000003F);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_in_ready",  32'(in_ready),  32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("bp_next_accepted", 32'(dut.r_state), 32'(ST_RUN));
        in_valid = 1'b0;
        wait_done(lat, busy_ok);
        check("bp_next_latency", 32'(lat), 32'd16);
        check("bp_next_product", product, 32'h00000001);
        @(posedge clk); #1;

        // Busy ignore: operand changes and in_valid during RUN have no effect
        start_op(16'h1234, 16'h0010);
        repeat (3) @(posedge clk);
        #1;
        op_a     = 16'hFFFF;
        op_b     = 16'hFFFF;
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat, busy_ok);
        check("busy_latency", 32'(lat + 7), 32'd16);
        check("busy_product", product, 32'h00012340);
        @(posedge clk); #1;

        // Asynchronous reset between edges at iteration 7
        start_op(16'hFFFF, 16'hFFFF);
        repeat (7) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_product",   product,        32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_op(16'h00FF, 16'h0101);
        wait_done(lat, busy_ok);
        check("arst_fresh_latency", 32'(lat), 32'd16);
        check("arst_fresh_product", product, 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
